// File: rtl/innerproduct_stream.sv
// innerproduct_stream: streaming inner product hprime = sum(x[i]*theta[i]).
// The vector arrives LANES features per beat; coefficients are held in a
// register file that can be loaded at run time.
// Optional feature macro: INNERPRODUCT_SAT_EN
//   defined   -> every accumulator update clamps to the AW-bit signed range
//                and h_sat reports whether any clamp happened in the vector
//   undefined -> the accumulator wraps modulo 2^AW and h_sat stays 0
module innerproduct_stream #(
  parameter int XW    = 7,
  parameter int TW    = 16,
  parameter int N     = 81,
  parameter int LANES = 3,
  parameter int AW    = 32,
  localparam int TAW  = (N > 1) ? $clog2(N) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               th_we,
  input  logic [TAW-1:0]     th_addr,
  input  logic [TW-1:0]      th_data,
  input  logic               x_valid,
  output logic               x_ready,
  input  logic [LANES*XW-1:0] x_data,
  output logic               h_valid,
  input  logic               h_ready,
  output logic [AW-1:0]      h_data,
  output logic               h_sat
);

  localparam int          NB = (N + LANES - 1) / LANES;
  localparam int          BW = (NB > 1) ? $clog2(NB) : 1;
  localparam int          PW = XW + 1 + TW;
  localparam int          SW = PW + $clog2(LANES) + 1;
  localparam int unsigned NU = N;

  typedef enum logic {S_ACC, S_HOLD} state_t;

  state_t                 state;
  logic signed [TW-1:0]   theta [N];
  logic [BW-1:0]          beat;
  logic signed [AW-1:0]   acc;
  logic signed [AW-1:0]   acc_next;
  logic signed [SW-1:0]   beat_sum;
  logic                   sat_run;
  logic                   sat_next;
  logic                   clamp;
  logic                   h_sat_q;
  logic                   accept;
  logic                   last;

`ifdef INNERPRODUCT_SAT_EN
  localparam int EW = ((AW > SW) ? AW : SW) + 1;
  localparam logic signed [EW-1:0] SMAX = {{(EW-AW+1){1'b0}}, {(AW-1){1'b1}}};
  localparam logic signed [EW-1:0] SMIN = {{(EW-AW+1){1'b1}}, {(AW-1){1'b0}}};
  logic signed [EW-1:0]   sum_ext;
`endif

  assign h_valid = (state == S_HOLD);
  assign x_ready = (state == S_ACC) || h_ready;
  assign accept  = x_valid && x_ready;
  assign last    = (beat == BW'(NB - 1));
  assign h_sat   = h_sat_q;

  // Coefficient register file; out-of-range addresses are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NU; i++) theta[i] <= '0;
    end else if (th_we && (32'(th_addr) < NU)) begin
      theta[th_addr] <= th_data;
    end
  end

  // Sum of the lane products for the current beat; padding lanes add nothing.
  always_comb begin
    int unsigned          idx;
    logic signed [PW-1:0] xe;
    logic signed [PW-1:0] te;
    logic signed [PW-1:0] prod;
    beat_sum = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      idx  = 32'(beat) * LANES + k;
      xe   = {{(TW+1){1'b0}}, x_data[k*XW +: XW]};
      te   = '0;
      if (idx < NU) te = {{(XW+1){theta[TAW'(idx)][TW-1]}}, theta[TAW'(idx)]};
      prod = xe * te;
      beat_sum = beat_sum + {{(SW-PW){prod[PW-1]}}, prod};
    end
  end

  // Next accumulator value: clamped or wrapping depending on build option.
  always_comb begin
`ifdef INNERPRODUCT_SAT_EN
    sum_ext  = EW'(acc) + EW'(beat_sum);
    clamp    = 1'b0;
    acc_next = sum_ext[AW-1:0];
    if (sum_ext > SMAX) begin
      acc_next = SMAX[AW-1:0];
      clamp    = 1'b1;
    end else if (sum_ext < SMIN) begin
      acc_next = SMIN[AW-1:0];
      clamp    = 1'b1;
    end
`else
    acc_next = acc + AW'(beat_sum);
    clamp    = 1'b0;
`endif
    sat_next = sat_run | clamp;
  end

  // Beat counter, accumulator and ACC/HOLD control with registered result.
  // The accumulator is cleared on the final beat so the result lives only in
  // h_data, letting the next vector start while the result is still held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_ACC;
      beat    <= '0;
      acc     <= '0;
      sat_run <= 1'b0;
      h_data  <= '0;
      h_sat_q <= 1'b0;
    end else begin
      if (h_valid && h_ready) state <= S_ACC;
      if (accept) begin
        if (last) begin
          beat    <= '0;
          acc     <= '0;
          sat_run <= 1'b0;
          h_data  <= acc_next;
          h_sat_q <= sat_next;
          state   <= S_HOLD;
        end else begin
          beat    <= beat + BW'(1);
          acc     <= acc_next;
          sat_run <= sat_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_innerproduct_stream.sv
// Directed testbench for innerproduct_stream: a default instance (N=81,
// LANES=3, AW=32) and a small instance (N=5, LANES=3, AW=16). Expected results
// come from a plain arithmetic model of the inner product with per-beat
// clamp/wrap, checked every cycle against the result handshake.
module tb_innerproduct_stream;

  localparam int BN = 81, BNB = 27, BAW = 32;
  localparam int SN = 5,  SNB = 2,  SAW = 16;
  localparam int L  = 3;

  typedef struct {
    longint d;
    bit     s;
  } res_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        b_th_we, b_x_valid, b_x_ready, b_h_valid, b_h_ready, b_h_sat;
  logic [6:0]  b_th_addr;
  logic [15:0] b_th_data;
  logic [20:0] b_x_data;
  logic [31:0] b_h_data;

  logic        s_th_we, s_x_valid, s_x_ready, s_h_valid, s_h_ready, s_h_sat;
  logic [2:0]  s_th_addr;
  logic [15:0] s_th_data;
  logic [20:0] s_x_data;
  logic [15:0] s_h_data;

  innerproduct_stream u_big (
    .clk(clk), .rst_n(rst_n), .th_we(b_th_we), .th_addr(b_th_addr),
    .th_data(b_th_data), .x_valid(b_x_valid), .x_ready(b_x_ready),
    .x_data(b_x_data), .h_valid(b_h_valid), .h_ready(b_h_ready),
    .h_data(b_h_data), .h_sat(b_h_sat)
  );

  innerproduct_stream #(.N(SN), .LANES(L), .AW(SAW)) u_small (
    .clk(clk), .rst_n(rst_n), .th_we(s_th_we), .th_addr(s_th_addr),
    .th_data(s_th_data), .x_valid(s_x_valid), .x_ready(s_x_ready),
    .x_data(s_x_data), .h_valid(s_h_valid), .h_ready(s_h_ready),
    .h_data(s_h_data), .h_sat(s_h_sat)
  );

  int   nvec = 0;
  int   nerr = 0;
  int   stalls = 0;
  int   bx [BN];
  int   bth[BN];
  int   sx [SN];
  int   sth[SN];
  res_t bq[$];
  res_t sq[$];
  res_t r;

  function automatic void chk(input string name, input longint act, input longint req);
    nvec++;
    if (act != req) begin
      nerr++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endfunction

  // Inner product of the model arrays, accumulated beat by beat.
  function automatic res_t model(input bit sm);
    int     n;
    int     aw;
    int     i;
    longint acc, s, mx, mn, m;
    res_t   res;
    n   = sm ? SN : BN;
    aw  = sm ? SAW : BAW;
    m   = 64'sd1 <<< aw;
    mx  = (64'sd1 <<< (aw - 1)) - 1;
    mn  = -(64'sd1 <<< (aw - 1));
    acc = 0;
    res.s = 1'b0;
    for (int b = 0; b < (n + L - 1) / L; b++) begin
      s = 0;
      for (int k = 0; k < L; k++) begin
        i = b * L + k;
        if (i < n) s += sm ? longint'(sx[i]) * longint'(sth[i])
                           : longint'(bx[i]) * longint'(bth[i]);
      end
      acc += s;
`ifdef INNERPRODUCT_SAT_EN
      if (acc > mx) begin acc = mx; res.s = 1'b1; end
      else if (acc < mn) begin acc = mn; res.s = 1'b1; end
`else
      acc = acc & (m - 1);
      if (acc > mx) acc -= m;
`endif
    end
    res.d = acc;
    return res;
  endfunction

  // Result checker: h_valid must track outstanding results; data checked while valid.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("b_valid", b_h_valid, bq.size() != 0);
      if (b_h_valid && bq.size() != 0) begin
        chk("b_data", longint'($signed(b_h_data)), bq[0].d);
        chk("b_sat", b_h_sat, bq[0].s);
        if (b_h_ready) void'(bq.pop_front());
      end
      chk("s_valid", s_h_valid, sq.size() != 0);
      if (s_h_valid && sq.size() != 0) begin
        chk("s_data", longint'($signed(s_h_data)), sq[0].d);
        chk("s_sat", s_h_sat, sq[0].s);
        if (s_h_ready) void'(sq.pop_front());
      end
    end
  end

  task automatic load(input bit sm, input int i, input int v);
    if (sm) begin
      s_th_we = 1'b1; s_th_addr = 3'(i); s_th_data = 16'(v);
    end else begin
      b_th_we = 1'b1; b_th_addr = 7'(i); b_th_data = 16'(v);
    end
    @(posedge clk); #1;
    b_th_we = 1'b0;
    s_th_we = 1'b0;
    if (sm && i < SN) sth[i] = v;
    if (!sm && i < BN) bth[i] = v;
  endtask

  // Send nbeats beats of the model vector; optionally write theta[0] during beat 0.
  task automatic send(input bit sm, input int nbeats, input bit wr0, input int wval, input int pad);
    int   n, nb, i, v;
    bit   ok;
    res_t res;
    n   = sm ? SN : BN;
    nb  = sm ? SNB : BNB;
    res = model(sm);
    for (int b = 0; b < nbeats; b++) begin
      for (int k = 0; k < L; k++) begin
        i = b * L + k;
        v = (i < n) ? (sm ? sx[i] : bx[i]) : pad;
        if (sm) s_x_data[k*7 +: 7] = 7'(v);
        else    b_x_data[k*7 +: 7] = 7'(v);
      end
      if (sm) s_x_valid = 1'b1; else b_x_valid = 1'b1;
      if (wr0 && b == 0) begin
        if (sm) begin s_th_we = 1'b1; s_th_addr = '0; s_th_data = 16'(wval); end
        else    begin b_th_we = 1'b1; b_th_addr = '0; b_th_data = 16'(wval); end
      end
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
        @(negedge clk);
        ok = sm ? s_x_ready : b_x_ready;
        @(posedge clk); #1;
        if (ok) break;
        stalls++;
      end
      b_th_we = 1'b0;
      s_th_we = 1'b0;
      if (!ok) begin
        chk("x_accept_timeout", 0, 1);
        b_x_valid = 1'b0;
        s_x_valid = 1'b0;
        return;
      end
      if (b == nb - 1) begin
        if (sm) sq.push_back(res); else bq.push_back(res);
      end
    end
    b_x_valid = 1'b0;
    s_x_valid = 1'b0;
  endtask

  task automatic drain();
    int c = 0;
    while ((bq.size() != 0 || sq.size() != 0) && c < 300) begin
      @(posedge clk); #1;
      c++;
    end
    chk("drain", bq.size() + sq.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    b_th_we = 0; b_th_addr = '0; b_th_data = '0; b_x_valid = 0; b_x_data = '0; b_h_ready = 1;
    s_th_we = 0; s_th_addr = '0; s_th_data = '0; s_x_valid = 0; s_x_data = '0; s_h_ready = 1;
    foreach (bx[i]) begin bx[i] = 0; bth[i] = 0; end
    foreach (sx[i]) begin sx[i] = 0; sth[i] = 0; end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_x_ready", b_x_ready, 1);
    chk("rst_h_valid", b_h_valid, 0);
    chk("rst_h_data", b_h_data, 0);
    chk("rst_h_sat", b_h_sat, 0);
    chk("rst_s_x_ready", s_x_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // All ones coefficients, all 127 features, two vectors back to back.
    for (int i = 0; i < BN; i++) begin load(0, i, 1); bx[i] = 127; end
    r = model(0);
    chk("model_all127", r.d, 10287);
    stalls = 0;
    send(0, BNB, 0, 0, 0);
    send(0, BNB, 0, 0, 0);
    chk("b2b_stalls", stalls, 0);
    drain();

    // Alternating -2/3 coefficients, x[i] = i mod 128.
    for (int i = 0; i < BN; i++) begin
      load(0, i, (i % 2 == 0) ? -2 : 3);
      bx[i] = i % 128;
    end
    r = model(0);
    chk("model_alt", r.d, 1520);
    send(0, BNB, 0, 0, 0);
    drain();

    // Downstream back-pressure for 10 cycles, then release.
    b_h_ready = 1'b0;
    fork
      begin
        send(0, BNB, 0, 0, 0);
        send(0, BNB, 0, 0, 0);
      end
      begin
        for (int c = 0; c < 200; c++) begin
          @(negedge clk);
          if (b_h_valid) break;
        end
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          chk("hold_valid", b_h_valid, 1);
          chk("hold_x_ready", b_x_ready, 0);
        end
        @(posedge clk); #1;
        b_h_ready = 1'b1;
        @(negedge clk);
        chk("release_accept", b_x_ready && b_x_valid, 1);
      end
    join
    drain();

    // Small instance: padding lane ignored, out-of-range write ignored.
    for (int i = 0; i < SN; i++) begin load(1, i, 1); sx[i] = 1; end
    load(1, 5, 999);
    r = model(1);
    chk("model_pad", r.d, 5);
    send(1, SNB, 0, 0, 127);
    // Write theta[0] in the same cycle as beat 0: beat sees the old value.
    send(1, SNB, 1, 100, 127);
    sth[0] = 100;
    r = model(1);
    chk("model_newtheta", r.d, 104);
    send(1, SNB, 0, 0, 127);
    drain();

    // Overflow on a 16-bit accumulator.
    for (int i = 0; i < SN; i++) begin load(1, i, 32767); sx[i] = 127; end
    r = model(1);
`ifdef INNERPRODUCT_SAT_EN
    chk("model_sat_data", r.d, 32767);
    chk("model_sat_flag", r.s, 1);
`else
    chk("model_wrap_data", r.d, 32133);
    chk("model_wrap_flag", r.s, 0);
`endif
    send(1, SNB, 0, 0, 127);
    // Saturation flag must not carry into the next vector.
    for (int i = 0; i < SN; i++) begin load(1, i, 1); sx[i] = 1; end
    send(1, SNB, 0, 0, 127);
    drain();

    // Reset in the middle of a vector.
    for (int i = 0; i < BN; i++) bx[i] = 5;
    send(0, 10, 0, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst_h_valid", b_h_valid, 0);
    chk("midrst_x_ready", b_x_ready, 1);
    chk("midrst_h_data", b_h_data, 0);
    chk("midrst_h_sat", b_h_sat, 0);
    bq.delete();
    sq.delete();
    foreach (bth[i]) bth[i] = 0;
    foreach (sth[i]) sth[i] = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < BN; i++) bx[i] = 127;
    r = model(0);
    chk("model_after_rst", r.d, 0);
    send(0, BNB, 0, 0, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
